// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 host blocks.
//   ps2_tx_state_e   host transmitter FSM states
//   PS2_FRAME_BITS   device clock falls per host-to-device frame
//   odd_parity()     parity bit that makes the 9-bit data+parity odd
//   PS2_CMD_*        common keyboard command bytes
package ps2_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_ACK,
    S_WAIT_IDLE
  } ps2_tx_state_e;

  localparam int PS2_FRAME_BITS = 11;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: synchroniser and glitch filter for one PS/2 line.
// A new level is accepted only after FILTER_LEN consecutive synchronised
// samples disagree with the current filtered level.
// Ports:
//   clk      system clock
//   rst      synchronous, active-high reset (filtered level resets to 1)
//   line_in  raw asynchronous line
//   level    filtered line level
//   fall     one-cycle pulse, coincident with level going 1 -> 0
module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic level,
  output logic fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    fall_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        level_d = sync2_q;
        fall_d  = level_q;  // disagreeing sample while level is 1 means a fall
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= line_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter. Sends one command byte per
// tx_valid/tx_ready handshake: inhibit, start, 8 data bits LSB first, odd
// parity, stop, then samples the device ACK.
// Optional build macro PS2_TX_RETRY_EN: on no-ACK or watchdog timeout the
// frame is retried once from INHIBIT; only the final status is reported.
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   tx_data, tx_valid        command byte and request
//   tx_ready                 high only in IDLE
//   clk_key_in, data_key_in  raw PS/2 line levels (asynchronous)
//   clk_key_oe, data_key_oe  1 = pull line low, 0 = release
//   busy                     transfer in progress
//   done                     one-cycle end-of-transfer pulse
//   ack_ok, timeout          status, valid with done
//
// state       | meaning
// ------------+--------------------------------------------------------
// S_IDLE      | ready for a request
// S_INHIBIT   | clock held low; data pulled low in the final cycle
// S_START     | clock released, start bit on data, wait fall 1
// S_DATA      | data bits driven on falls 1..8, fall 9 drives parity
// S_PARITY    | parity driven, fall 10 releases data (stop bit)
// S_STOP      | stop bit, fall 11 is the ACK clock
// S_ACK       | sample device ACK from filtered data
// S_WAIT_IDLE | wait for both lines high, then report
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       clk_key_in,
  input  logic       data_key_in,
  output logic       clk_key_oe,
  output logic       data_key_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       timeout
);

`ifdef PS2_TX_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  logic clk_filt, clk_fall, data_filt, data_fall_unused;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk     (clk),
    .rst     (rst),
    .line_in (clk_key_in),
    .level   (clk_filt),
    .fall    (clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk     (clk),
    .rst     (rst),
    .line_in (data_key_in),
    .level   (data_filt),
    .fall    (data_fall_unused)
  );

  ps2_tx_state_e state_q, state_d;
  logic [IW-1:0] inh_cnt_q, inh_cnt_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [7:0]    byte_q, byte_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic          ack_smp_q, ack_smp_d;
  logic          retry_q, retry_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          tx_ready_q, tx_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ack_ok_q, ack_ok_d;
  logic          timeout_q, timeout_d;

  logic active, wd_expired, restart, finish, fin_ack, fin_timeout;

  always_comb begin
    state_d     = state_q;
    inh_cnt_d   = inh_cnt_q;
    wd_d        = wd_q;
    byte_d      = byte_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    bit_idx_d   = bit_idx_q;
    ack_smp_d   = ack_smp_q;
    retry_d     = retry_q;
    clk_oe_d    = clk_oe_q;
    data_oe_d   = data_oe_q;
    tx_ready_d  = tx_ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ack_ok_d    = ack_ok_q;
    timeout_d   = timeout_q;
    restart     = 1'b0;
    finish      = 1'b0;
    fin_ack     = 1'b0;
    fin_timeout = 1'b0;

    // Watchdog runs from START entry until the frame is reported.
    active     = (state_q != S_IDLE) && (state_q != S_INHIBIT);
    wd_expired = active && (wd_q == '0);
    if (active && (wd_q != '0)) wd_d = wd_q - 1'b1;

    if (wd_expired) begin
      // Checked before the case so a timeout wins over a coincident fall.
      if (RETRY_EN && !retry_q) begin
        restart = 1'b1;
      end else begin
        finish      = 1'b1;
        fin_timeout = 1'b1;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          retry_d = 1'b0;
          if (tx_valid) begin
            byte_d    = tx_data;
            shift_d   = tx_data;
            parity_d  = odd_parity(tx_data);
            ack_ok_d  = 1'b0;
            timeout_d = 1'b0;
            restart   = 1'b1;
          end
        end
        S_INHIBIT: begin
          inh_cnt_d = inh_cnt_q - 1'b1;
          if (inh_cnt_q == IW'(1)) data_oe_d = 1'b1;
          if (inh_cnt_q == '0) begin
            state_d   = S_START;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b1;
            wd_d      = WW'(TIMEOUT_CYCLES - 1);
          end
        end
        S_START: begin
          if (clk_fall) begin
            data_oe_d = ~shift_q[0];
            shift_d   = shift_q >> 1;
            bit_idx_d = 3'd0;
            state_d   = S_DATA;
          end
        end
        S_DATA: begin
          if (clk_fall) begin
            if (bit_idx_q == 3'd7) begin
              data_oe_d = ~parity_q;
              state_d   = S_PARITY;
            end else begin
              data_oe_d = ~shift_q[0];
              shift_d   = shift_q >> 1;
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end
        end
        S_PARITY: begin
          if (clk_fall) begin
            data_oe_d = 1'b0;
            state_d   = S_STOP;
          end
        end
        S_STOP: begin
          if (clk_fall) state_d = S_ACK;
        end
        S_ACK: begin
          // Device holds ACK low through the whole clock-low phase of fall 11.
          ack_smp_d = ~data_filt;
          state_d   = S_WAIT_IDLE;
        end
        S_WAIT_IDLE: begin
          if (clk_filt && data_filt) begin
            if (!ack_smp_q && RETRY_EN && !retry_q) begin
              restart = 1'b1;
            end else begin
              finish  = 1'b1;
              fin_ack = ack_smp_q;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (restart) begin
      state_d    = S_INHIBIT;
      inh_cnt_d  = IW'(INHIBIT_CYCLES - 1);
      clk_oe_d   = 1'b1;
      data_oe_d  = 1'b0;
      tx_ready_d = 1'b0;
      busy_d     = 1'b1;
      if (state_q != S_IDLE) begin
        retry_d = 1'b1;
        shift_d = byte_q;
      end
    end

    if (finish) begin
      state_d    = S_IDLE;
      clk_oe_d   = 1'b0;
      data_oe_d  = 1'b0;
      tx_ready_d = 1'b1;
      busy_d     = 1'b0;
      done_d     = 1'b1;
      ack_ok_d   = fin_ack;
      timeout_d  = fin_timeout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      inh_cnt_q  <= '0;
      wd_q       <= '0;
      byte_q     <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      bit_idx_q  <= '0;
      ack_smp_q  <= 1'b0;
      retry_q    <= 1'b0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_ok_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      inh_cnt_q  <= inh_cnt_d;
      wd_q       <= wd_d;
      byte_q     <= byte_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      bit_idx_q  <= bit_idx_d;
      ack_smp_q  <= ack_smp_d;
      retry_q    <= retry_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ack_ok_q   <= ack_ok_d;
      timeout_q  <= timeout_d;
    end
  end

  assign tx_ready    = tx_ready_q;
  assign clk_key_oe  = clk_oe_q;
  assign data_key_oe = data_oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign ack_ok      = ack_ok_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: drives ps2_host_tx against a behavioural PS/2 keyboard
// that clocks the frame, samples bits on rising edges and optionally ACKs.
// Expected frames come from the byte's arithmetic (LSB first, odd parity).
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 60;
  localparam int TOUT = 3000;
  localparam int FLEN = 4;
  localparam int WAIT_LIM = INH + TOUT + 400;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, clk_key_oe, data_key_oe, busy, done, ack_ok, timeout;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       clk_line, data_line;

  assign clk_line  = dev_clk & ~clk_key_oe;
  assign data_line = dev_data & ~data_key_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TOUT),
    .FILTER_LEN     (FLEN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .clk_key_in  (clk_line),
    .data_key_in (data_line),
    .clk_key_oe  (clk_key_oe),
    .data_key_oe (data_key_oe),
    .busy        (busy),
    .done        (done),
    .ack_ok      (ack_ok),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line monitor: inhibit run length, clock release time, done status.
  int   cyc = 0, inh_run = 0, inh_len = 0, release_cyc = 0;
  int   done_cnt = 0, done_cyc = 0;
  logic last_inh_data = 1'b0, inh_data_low = 1'b0;
  logic done_ack = 1'b0, done_to = 1'b0, done_oe = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (clk_key_oe) begin
      inh_run++;
      last_inh_data = data_key_oe;
    end else if (inh_run != 0) begin
      inh_len      = inh_run;
      inh_data_low = last_inh_data;
      inh_run      = 0;
      release_cyc  = cyc;
    end
    if (done) begin
      done_cnt++;
      done_ack = ack_ok;
      done_to  = timeout;
      done_oe  = clk_key_oe | data_key_oe;
      done_cyc = cyc;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    check("ready_before_req", tx_ready, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  // Keyboard model: waits for inhibit then release, then clocks last_fall falls.
  task automatic dev_frame(input int half, input bit do_ack, input int glitch_at,
                           input int last_fall, output logic [10:0] got, output bit ok);
    int n;
    got = '1;
    ok  = 1'b1;
    n   = 0;
    while (!clk_key_oe && n < WAIT_LIM) begin @(negedge clk); n++; end
    while (clk_key_oe && n < WAIT_LIM) begin @(negedge clk); n++; end
    if (n >= WAIT_LIM) begin
      ok = 1'b0;
    end else begin
      got[0] = data_line;
      repeat (half) @(negedge clk);
      for (int k = 1; k <= last_fall; k++) begin
        dev_clk = 1'b0;
        repeat (half) @(negedge clk);
        dev_clk = 1'b1;
        if (k < PS2_FRAME_BITS) got[k] = data_line;
        if (k == PS2_FRAME_BITS - 1 && do_ack) dev_data = 1'b0;
        if (k == glitch_at) begin
          repeat (6) @(negedge clk);
          dev_clk = 1'b0;
          repeat (2) @(negedge clk);
          dev_clk = 1'b1;
          repeat (half - 8) @(negedge clk);
        end else begin
          repeat (half) @(negedge clk);
        end
        if (k == PS2_FRAME_BITS) dev_data = 1'b1;
      end
    end
  endtask

  task automatic check_frame(input logic [7:0] b, input logic [10:0] got);
    int   ones;
    logic exp_par;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += (b >> i) & 1;
    exp_par = (ones % 2 == 0);
    check("start_bit", got[0], 0);
    check("data_bits", got[8:1], b);
    check("parity_bit", got[9], exp_par);
    check("stop_bit", got[10], 1);
    check("inhibit_len", inh_len, INH);
    check("data_low_before_release", inh_data_low, 1);
  endtask

  task automatic do_xfer(input logic [7:0] b, input int half, input bit ack1, input int glitch_at);
    int         d0;
    logic [10:0] got;
    bit         ok;
    d0 = done_cnt;
    send_byte(b);
    dev_frame(half, ack1, glitch_at, PS2_FRAME_BITS, got, ok);
    check("frame_started", ok, 1);
    check_frame(b, got);
`ifdef PS2_TX_RETRY_EN
    if (!ack1) begin
      dev_frame(half, 1'b0, 0, PS2_FRAME_BITS, got, ok);
      check("retry_frame_started", ok, 1);
      check_frame(b, got);
    end
`endif
    repeat (40) @(negedge clk);
    check("done_pulses", done_cnt - d0, 1);
    check("ack_ok", done_ack, ack1);
    check("timeout_flag", done_to, 0);
    check("oe_at_done", done_oe, 0);
    check("ready_after", tx_ready, 1);
    check("busy_after", busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_time_limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    int          d0, n;
    logic [10:0] got;
    bit          ok;

    repeat (4) @(negedge clk);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_oe", {clk_key_oe, data_key_oe}, 0);
    check("rst_status", {ack_ok, timeout}, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    do_xfer(PS2_CMD_SET_LEDS, 20, 1'b1, 0);
    do_xfer(8'h00, 16, 1'b1, 0);
    do_xfer(8'h5A, 14, 1'b0, 0);
    do_xfer(8'hC3, 18, 1'b1, 4);

    for (int i = 0; i < 6; i++) begin
      do_xfer(8'($urandom), int'($urandom_range(12, 24)), 1'($urandom_range(0, 1)),
              (i < 2) ? int'($urandom_range(2, 8)) : 0);
    end

    // Watchdog: device never clocks after release.
    d0 = done_cnt;
    send_byte(8'h3C);
    n = 0;
    while (done_cnt == d0 && n < 3 * TOUT + 4 * INH) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    check("to_done_pulses", done_cnt - d0, 1);
    check("to_latency", done_cyc - release_cyc, TOUT);
    check("to_flag", done_to, 1);
    check("to_ack", done_ack, 0);
    check("to_oe", done_oe, 0);

    // Reset while bit 4 is on the line.
    d0 = done_cnt;
    send_byte(8'hA5);
    dev_frame(16, 1'b1, 0, 5, got, ok);
    check("rst_frame_started", ok, 1);
    check("rst_bits_so_far", got[5:1], 5'h05);
    check("rst_pre_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_oe", {clk_key_oe, data_key_oe}, 0);
    check("rst_mid_ready", tx_ready, 1);
    check("rst_mid_busy", busy, 0);
    rst = 1'b0;
    dev_clk = 1'b1;
    dev_data = 1'b1;
    repeat (30) @(negedge clk);
    check("rst_mid_no_done", done_cnt - d0, 0);
    do_xfer(PS2_CMD_RESET, 15, 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
